// File: rtl/result_fifo.sv
// result_fifo: show-ahead FIFO buffering datapath result words between OUTR
// and a slower consumer, with valid/ready handshakes on both sides.
//
// Optional feature macro: RESULT_FIFO_OVF_EN
//   undefined : in_ready = !full, so words offered while full are held back
//               upstream; overflow is tied to 0.
//   defined   : in_ready is always 1. A word offered while full with no pop
//               in the same cycle is dropped and sets the sticky overflow flag.
//
// Parameters:
//   WIDTH     data width in bits
//   DEPTH     number of entries (power of two, >= 2)
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   in_data   result word from OUTR
//   in_valid  in_data is valid this cycle
//   in_ready  FIFO accepts a word this cycle
//   out_data  oldest stored word (show-ahead; meaningful only when out_valid)
//   out_valid out_data holds a stored word
//   out_ready consumer takes out_data this cycle
//   count     current number of entries
//   overflow  sticky; a word was dropped while full
module result_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Status flags come straight from the registered count, so they follow
    // the asynchronous reset without waiting for a clock edge.
    assign empty     = (count_q == CW'(0));
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

`ifdef RESULT_FIFO_OVF_EN
    logic overflow_q, overflow_d;
    logic drop;

    // Never back-pressure; while full a write only lands if a slot frees up
    // in the same cycle.
    assign in_ready = 1'b1;
    assign push     = in_valid && (!full || pop);
    assign drop     = in_valid && full && !pop;
    assign overflow = overflow_q;

    // Sticky drop flag, cleared only by reset.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end
`else
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign overflow = 1'b0;
`endif

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array is not reset; writes are suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_result_fifo.sv
// Scoreboarded bench for result_fifo (WIDTH=4, DEPTH=4). Stimulus queues the
// words it expects to be accepted; a monitor pops and compares them whenever
// the consumer handshake completes.
module tb_result_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0] exp_q [$];

    result_fifo #(.WIDTH(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Push a word the FIFO must accept, one cycle, consumer stalled.
    task automatic push_word(input logic [3:0] d);
        drive(1'b1, d, 1'b0);
        exp_q.push_back(d);
        cyc();
    endtask

    // Drain with out_ready high, bounded by a cycle budget.
    task automatic drain(input string name);
        int n;
        n = 0;
        drive(1'b0, 4'h0, 1'b1);
        while (out_valid && n < 10) begin
            cyc();
            n++;
        end
        check({name, "_drained"}, int'(out_valid), 0);
        check({name, "_count0"}, int'(count), 0);
        drive(1'b0, 4'h0, 1'b0);
    endtask

    // Monitor: at the falling edge inputs and outputs are stable; a completed
    // handshake means the front of the scoreboard must be on out_data.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL pop_unexpected: got %0h expected no word", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data != e) begin
                        n_bad++;
                        $display("FAIL pop_data: got %0h expected %0h", out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 1'b0);
        #2;
        check("rst_count", int'(count), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_overflow", int'(overflow), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-stream: asynchronous clear between edges.
        push_word(4'h3);
        push_word(4'h5);
        drive(1'b0, 4'h0, 1'b0);
        check("mid_count2", int'(count), 2);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        exp_q.delete();
        #1 rst = 1'b0;
        cyc();
        check("post_rst_empty", int'(out_valid), 0);
        check("post_rst_count", int'(count), 0);

        // Order and pointer wrap.
        push_word(4'h1);
        push_word(4'h2);
        push_word(4'h3);
        drive(1'b0, 4'h0, 1'b1);
        cyc();
        cyc();
        check("wrap_count1", int'(count), 1);
        push_word(4'h4);
        push_word(4'h5);
        push_word(4'h6);
        check("wrap_count4", int'(count), 4);
        drain("wrap");

        // Fill to full.
`ifdef RESULT_FIFO_OVF_EN
        push_word(4'h1);
        push_word(4'h2);
        push_word(4'h3);
        push_word(4'h4);
        check("full_count", int'(count), 4);
        check("full_in_ready_ovf", int'(in_ready), 1);
        drive(1'b1, 4'h9, 1'b0);
        cyc();
        check("ovf_set", int'(overflow), 1);
        check("ovf_count", int'(count), 4);
        drain("ovf");
        check("ovf_sticky", int'(overflow), 1);

        // Full, push while popping: 7 goes in behind the four stored words.
        push_word(4'h1);
        push_word(4'h2);
        push_word(4'h3);
        push_word(4'h4);
        drive(1'b1, 4'h7, 1'b1);
        exp_q.push_back(4'h7);
        cyc();
        check("full_pp_count", int'(count), 4);
        drain("full_pp");
`else
        push_word(4'hA);
        push_word(4'hB);
        push_word(4'hC);
        push_word(4'hD);
        check("full_count", int'(count), 4);
        check("full_in_ready", int'(in_ready), 0);
        drive(1'b1, 4'hE, 1'b0);
        cyc();
        check("bp_count", int'(count), 4);
        check("bp_overflow", int'(overflow), 0);
        drain("bp");
        check("bp_overflow_after", int'(overflow), 0);
`endif

        // Simultaneous push and pop at count 2.
        push_word(4'h8);
        push_word(4'h9);
        drive(1'b1, 4'hA, 1'b1);
        exp_q.push_back(4'hA);
        cyc();
        check("pp2_count_a", int'(count), 2);
        drive(1'b1, 4'hB, 1'b1);
        exp_q.push_back(4'hB);
        cyc();
        check("pp2_count_b", int'(count), 2);
        drain("pp2");

        // Streaming at one word per cycle.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'(i), 1'b1);
            exp_q.push_back(4'(i));
            cyc();
            n_total++;
            if (count > 3'd1) begin
                n_bad++;
                $display("FAIL stream_count: got %0d expected at most 1", count);
            end
        end
        drain("stream");
        check("scoreboard_empty", exp_q.size(), 0);

        // Reset clears overflow (and everything else).
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        check("final_overflow", int'(overflow), 0);
        check("final_count", int'(count), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
